// File: rtl/seven_seg_scan_driver.sv
// Seven-segment scan driver: shadows register-file contents at frame
// boundaries and time-multiplexes a common-anode display with PWM dimming.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int GUARD_CYC      = 16,
    parameter int PWM_BITS       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    enable,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [2:0]              cur_digit,
    output logic                    frame_tick
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] GUARD    = PRE_W'(GUARD_CYC);
    localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic [PRE_W-1:0]        prescaler;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic                    load_pending;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_enable;
    logic [PWM_BITS-1:0]     sh_bright;

    logic                    slot_wrap;
    logic                    shadow_load;
    logic [3:0]              nibble;
    logic                    dp_bit;
    logic                    blank_bit;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    lit;
    logic [6:0]              pattern;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    assign slot_wrap   = (prescaler == PRE_LAST);
    assign shadow_load = load_pending
                       | (slot_wrap & (cur_digit == DIG_LAST));

    // Slot timing runs regardless of content so frame rate never changes.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            prescaler <= '0;
            cur_digit <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (slot_wrap) begin
                prescaler <= '0;
                if (cur_digit == DIG_LAST)
                    cur_digit <= '0;
                else
                    cur_digit <= cur_digit + 3'd1;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            load_pending <= 1'b1;
            frame_tick   <= 1'b0;
            sh_digits    <= '0;
            sh_dp        <= '0;
            sh_blank     <= '0;
            sh_enable    <= 1'b0;
            sh_bright    <= '0;
        end else begin
            load_pending <= 1'b0;
            frame_tick   <= shadow_load;
            if (shadow_load) begin
                sh_digits <= digit_data;
                sh_dp     <= dp_in;
                sh_blank  <= blank_mask;
                sh_enable <= enable;
                sh_bright <= brightness;
            end
        end
    end

    always_comb begin
        nibble    = '0;
        dp_bit    = 1'b0;
        blank_bit = 1'b1;
        digit_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cur_digit == 3'(k)) begin
                nibble       = sh_digits[4*k +: 4];
                dp_bit       = sh_dp[k];
                blank_bit    = sh_blank[k];
                digit_sel[k] = 1'b1;
            end
        end
    end

    // Active-high {g,f,e,d,c,b,a} hex glyphs.
    always_comb begin
        pattern = 7'h00;
        case (nibble)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            4'hF: pattern = 7'h71;
        endcase
    end

    // Guard window at slot start keeps the old digit from ghosting.
    assign lit = sh_enable
               & ~blank_bit
               & (prescaler >= GUARD)
               & (pwm_cnt < sh_bright);

    assign an_d  = lit ? digit_sel : '0;
    assign seg_d = lit ? pattern : 7'h00;
    assign dp_d  = lit & dp_bit;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= SEG_ACTIVE_LOW;
        end else begin
            an  <= an_d ^ AN_OFF;
            seg <= seg_d ^ SEG_OFF;
            dp  <= dp_d ^ SEG_ACTIVE_LOW;
        end
    end

endmodule
